cru_seq: RTL and testbench

CRU_SEQ -- requirements
Module: cru_seq

---
 rtl/cru_pkg.sv | 17 +
 rtl/cru_bit_timer.sv | 26 ++
 rtl/cru_seq.sv | 166 ++++++++++++++++
 tb/tb_cru_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cru_pkg.sv
// Shared types and constants for the CRU bit-serial sequencer.
package cru_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      DONE   = 2'd3
   } cru_state_t;

   localparam logic CRU_OP_STCR = 1'b0;
   localparam logic CRU_OP_LDCR = 1'b1;

   // CRU addresses are byte addresses, so consecutive bits are two apart
   localparam logic [15:0] CRU_ADDR_STEP = 16'd2;

endpackage

// File: rtl/cru_bit_timer.sv
// Per-phase down-counter: load a cycle count minus one, tc is high on the phase's last cycle.
module cru_bit_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             tc
);

   logic [WIDTH-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_value;
      end else if (cnt != '0) begin
         cnt <= cnt - WIDTH'(1);
      end
   end

   assign tc = (cnt == '0);

endmodule

// File: rtl/cru_seq.sv
// CRU bit-serial transfer sequencer (STCR read / LDCR write).
// Optional abort input is built when CRU_SEQ_ABORT_EN is defined.
module cru_seq
   import cru_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1,
   parameter int STROBE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        op,
   input  logic [15:0] base,
   input  logic [3:0]  count,
   input  logic [15:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [15:0] rdata,
   output logic [15:0] ab,
   output logic        cruout,
   output logic        cruclk,
   input  logic        cruin
`ifdef CRU_SEQ_ABORT_EN
   ,
   input  logic        abort
`endif
);

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
   localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

   cru_state_t  state, state_nxt;
   logic        op_q;
   logic [15:0] wdata_q;
   logic [3:0]  idx;
   logic [3:0]  last_idx;
   logic [3:0]  idx_nxt;
   logic        last_bit;

   logic        timer_load;
   logic [3:0]  timer_value;
   logic        timer_tc;
   logic        accept;
   logic        sample;
   logic        advance;
   logic        abort_act;

   assign idx_nxt  = idx + 4'd1;
   assign last_bit = (idx == last_idx);

`ifdef CRU_SEQ_ABORT_EN
   assign abort_act = abort && ((state == SETUP) || (state == STROBE));
`else
   assign abort_act = 1'b0;
`endif

   cru_bit_timer #(
      .WIDTH(4)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .load      (timer_load),
      .load_value(timer_value),
      .tc        (timer_tc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Reads sample on the last settle cycle; writes follow settle with a strobe phase.
   always_comb begin
      state_nxt   = state;
      timer_load  = 1'b0;
      timer_value = SETTLE_LOAD;
      accept      = 1'b0;
      sample      = 1'b0;
      advance     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               timer_load = 1'b1;
               state_nxt  = SETUP;
            end
         end
         SETUP: begin
            if (abort_act) begin
               state_nxt = DONE;
            end else if (timer_tc) begin
               if (op_q == CRU_OP_LDCR) begin
                  timer_load  = 1'b1;
                  timer_value = STROBE_LOAD;
                  state_nxt   = STROBE;
               end else begin
                  sample = 1'b1;
                  if (last_bit) begin
                     state_nxt = DONE;
                  end else begin
                     advance    = 1'b1;
                     timer_load = 1'b1;
                  end
               end
            end
         end
         STROBE: begin
            if (abort_act) begin
               state_nxt = DONE;
            end else if (timer_tc) begin
               if (last_bit) begin
                  state_nxt = DONE;
               end else begin
                  advance    = 1'b1;
                  timer_load = 1'b1;
                  state_nxt  = SETUP;
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Transfer datapath: address, write bit and read shift target.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q     <= CRU_OP_STCR;
         wdata_q  <= '0;
         last_idx <= '0;
         idx      <= '0;
         rdata    <= '0;
         ab       <= '0;
         cruout   <= 1'b0;
      end else if (accept) begin
         op_q     <= op;
         wdata_q  <= wdata;
         last_idx <= count - 4'd1;
         idx      <= '0;
         rdata    <= '0;
         ab       <= base;
         cruout   <= wdata[0];
      end else begin
         if (sample) begin
            rdata[idx] <= cruin;
         end
         if (advance) begin
            idx    <= idx_nxt;
            ab     <= ab + CRU_ADDR_STEP;
            cruout <= wdata_q[idx_nxt];
         end
      end
   end

   assign busy   = (state == SETUP) || (state == STROBE);
   assign done   = (state == DONE);
   assign cruclk = !((state == STROBE) && !abort_act);

endmodule

// File: tb/tb_cru_seq.sv
// Directed self-checking bench for cru_seq; abort steps compile in with CRU_SEQ_ABORT_EN.
module tb_cru_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        op = 1'b0;
   logic [15:0] base = '0;
   logic [3:0]  count = '0;
   logic [15:0] wdata = '0;
   logic        busy;
   logic        done;
   logic [15:0] rdata;
   logic [15:0] ab;
   logic        cruout;
   logic        cruclk;
   logic        cruin;
   logic        cruin_sel = 1'b0;
`ifdef CRU_SEQ_ABORT_EN
   logic        abort = 1'b0;
`endif

   int total = 0;
   int bad = 0;

   int          nstrobe = 0;
   int          ndone = 0;
   logic        prev_cruclk = 1'b1;
   logic [15:0] str_ab [64];
   logic        str_out [64];
   int          str_len [64];

   always #5 clk = ~clk;

   // Device model: odd bit positions read 1 when base is a multiple of 4
   assign cruin = cruin_sel ? 1'b1 : ab[1];

   cru_seq #(
      .SETTLE_CYCLES(1),
      .STROBE_CYCLES(2)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .base  (base),
      .count (count),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .rdata (rdata),
      .ab    (ab),
      .cruout(cruout),
      .cruclk(cruclk),
      .cruin (cruin)
`ifdef CRU_SEQ_ABORT_EN
      ,
      .abort (abort)
`endif
   );

   // Strobe/done monitor sampled mid-cycle on the falling clock edge
   always @(negedge clk) begin
      if (done) ndone++;
      if (!cruclk) begin
         if (prev_cruclk) begin
            if (nstrobe < 64) begin
               str_ab[nstrobe]  = ab;
               str_out[nstrobe] = cruout;
               str_len[nstrobe] = 1;
            end
            nstrobe++;
         end else if (nstrobe > 0 && nstrobe <= 64) begin
            str_len[nstrobe-1]++;
         end
      end
      prev_cruclk = cruclk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic op_i, input logic [15:0] base_i,
                                input logic [3:0] count_i, input logic [15:0] wdata_i);
      op    = op_i;
      base  = base_i;
      count = count_i;
      wdata = wdata_i;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic waitDone(output int cycles);
      cycles = -1;
      for (int c = 1; c <= 100; c++) begin
         tick();
         if (done) begin
            cycles = c;
            break;
         end
      end
   endtask

   int cyc;
   int s0;
   int d0;

   initial begin
      $display("[TB] reset state");
      tick();
      tick();
      checkOutput("rst_busy",   32'(busy),   32'd0);
      checkOutput("rst_done",   32'(done),   32'd0);
      checkOutput("rst_rdata",  32'(rdata),  32'd0);
      checkOutput("rst_ab",     32'(ab),     32'd0);
      checkOutput("rst_cruout", 32'(cruout), 32'd0);
      checkOutput("rst_cruclk", 32'(cruclk), 32'd1);
      rst = 1'b0;

      $display("[TB] LDCR count=4 at 1EE0, first start after reset");
      s0 = nstrobe;
      applyStimulus(1'b1, 16'h1EE0, 4'd4, 16'h000A);
      checkOutput("ldcr_busy",     32'(busy),   32'd1);
      checkOutput("ldcr_ab0",      32'(ab),     32'h1EE0);
      checkOutput("ldcr_setclk",   32'(cruclk), 32'd1);
      waitDone(cyc);
      checkOutput("ldcr_cycles",   32'(cyc),    32'd12);
      checkOutput("ldcr_strobes",  32'(nstrobe - s0), 32'd4);
      checkOutput("ldcr_ab_s0",    32'(str_ab[s0]),     32'h1EE0);
      checkOutput("ldcr_ab_s1",    32'(str_ab[s0+1]),   32'h1EE2);
      checkOutput("ldcr_ab_s2",    32'(str_ab[s0+2]),   32'h1EE4);
      checkOutput("ldcr_ab_s3",    32'(str_ab[s0+3]),   32'h1EE6);
      checkOutput("ldcr_out_s0",   32'(str_out[s0]),    32'd0);
      checkOutput("ldcr_out_s1",   32'(str_out[s0+1]),  32'd1);
      checkOutput("ldcr_out_s2",   32'(str_out[s0+2]),  32'd0);
      checkOutput("ldcr_out_s3",   32'(str_out[s0+3]),  32'd1);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("ldcr_len_s%0d", i), 32'(str_len[s0+i]), 32'd2);
      end
      checkOutput("ldcr_done_busy", 32'(busy),  32'd0);
      checkOutput("ldcr_rdata",     32'(rdata), 32'd0);
      tick();
      checkOutput("ldcr_done_low",  32'(done),   32'd0);
      checkOutput("ldcr_idle_ab",   32'(ab),     32'h1EE6);
      checkOutput("ldcr_idle_out",  32'(cruout), 32'd1);
      checkOutput("ldcr_idle_clk",  32'(cruclk), 32'd1);

      $display("[TB] STCR count=0 (16 bits)");
      cruin_sel = 1'b0;
      s0 = nstrobe;
      applyStimulus(1'b0, 16'h0100, 4'd0, 16'h0000);
      waitDone(cyc);
      checkOutput("stcr16_cycles",  32'(cyc),   32'd16);
      checkOutput("stcr16_rdata",   32'(rdata), 32'hAAAA);
      checkOutput("stcr16_strobes", 32'(nstrobe - s0), 32'd0);
      tick();
      checkOutput("stcr16_hold",    32'(rdata), 32'hAAAA);
      checkOutput("stcr16_ab",      32'(ab),    32'h011E);

      $display("[TB] STCR address wrap");
      applyStimulus(1'b0, 16'hFFFE, 4'd2, 16'h0000);
      checkOutput("wrap_ab0", 32'(ab), 32'hFFFE);
      tick();
      checkOutput("wrap_ab1", 32'(ab), 32'h0000);
      waitDone(cyc);
      checkOutput("wrap_cycles", 32'(cyc),   32'd1);
      checkOutput("wrap_rdata",  32'(rdata), 32'h0001);
      tick();

      $display("[TB] start while busy and in DONE is ignored");
      s0 = nstrobe;
      d0 = ndone;
      applyStimulus(1'b1, 16'h0040, 4'd3, 16'h0005);
      tick();
      tick();
      applyStimulus(1'b0, 16'h9000, 4'd1, 16'h0000);
      waitDone(cyc);
      checkOutput("busy_cycles", 32'(cyc), 32'd6);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      checkOutput("busy_idle", 32'(busy), 32'd0);
      for (int i = 0; i < 8; i++) tick();
      checkOutput("busy_strobes", 32'(nstrobe - s0), 32'd3);
      checkOutput("busy_dones",   32'(ndone - d0),   32'd1);
      checkOutput("busy_ab",      32'(ab),           32'h0044);

      $display("[TB] reset during second strobe");
      s0 = nstrobe;
      d0 = ndone;
      applyStimulus(1'b1, 16'h2000, 4'd4, 16'h000F);
      for (int i = 0; i < 4; i++) tick();
      checkOutput("mid_clk_low", 32'(cruclk), 32'd0);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("mid_clk",    32'(cruclk), 32'd1);
      checkOutput("mid_busy",   32'(busy),   32'd0);
      checkOutput("mid_done",   32'(done),   32'd0);
      checkOutput("mid_ab",     32'(ab),     32'd0);
      checkOutput("mid_cruout", 32'(cruout), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      checkOutput("mid_strobes", 32'(nstrobe - s0), 32'd2);
      checkOutput("mid_dones",   32'(ndone - d0),   32'd0);
      cruin_sel = 1'b1;
      applyStimulus(1'b0, 16'h0004, 4'd1, 16'h0000);
      checkOutput("mid_restart", 32'(busy), 32'd1);
      waitDone(cyc);
      checkOutput("mid_cycles", 32'(cyc),   32'd1);
      checkOutput("mid_rdata",  32'(rdata), 32'h0001);
      tick();

`ifdef CRU_SEQ_ABORT_EN
      $display("[TB] abort during STCR bit 2");
      cruin_sel = 1'b1;
      applyStimulus(1'b0, 16'h0300, 4'd8, 16'h0000);
      tick();
      tick();
      abort = 1'b1;
      #1;
      checkOutput("abt_clk", 32'(cruclk), 32'd1);
      tick();
      abort = 1'b0;
      checkOutput("abt_done",  32'(done),  32'd1);
      checkOutput("abt_busy",  32'(busy),  32'd0);
      checkOutput("abt_rdata", 32'(rdata), 32'h0003);
      tick();

      $display("[TB] abort during LDCR strobe");
      applyStimulus(1'b1, 16'h0400, 4'd2, 16'h0003);
      tick();
      checkOutput("abtw_low", 32'(cruclk), 32'd0);
      abort = 1'b1;
      #1;
      checkOutput("abtw_clk", 32'(cruclk), 32'd1);
      tick();
      abort = 1'b0;
      checkOutput("abtw_done", 32'(done), 32'd1);
      tick();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
